// File: rtl/datapath_sequencer_if.sv
// Bus between the instruction source and the datapath sequencer.
// Carries the start/ready handshake, the decoded fields and the control strobes.
interface datapath_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
);
    logic              start;
    logic              ready;
    logic [2:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rn;
    logic [2:0]        rm;
    logic [1:0]        shift_in;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              vsel;
    logic [1:0]        ALUop;
    logic [1:0]        shift;
    logic [DATA_W-1:0] sximm;
    logic              done;
    logic              err;

    modport master (
        output start, op, rd, rn, rm, shift_in, imm,
        input  ready, readnum, writenum, write,
        input  loada, loadb, loadc, loads,
        input  asel, bsel, vsel, ALUop, shift,
        input  sximm, done, err
    );

    modport slave (
        input  start, op, rd, rn, rm, shift_in, imm,
        output ready, readnum, writenum, write,
        output loada, loadb, loadc, loads,
        output asel, bsel, vsel, ALUop, shift,
        output sximm, done, err
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the 16-bit lab datapath.
// Latches one instruction per handshake and steps load/exec/write-back.
module datapath_sequencer #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic clk,
    input  logic reset_n,
    datapath_sequencer_if.slave bus
);
    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WB_REG,
        S_WB_IMM,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       rd_q, rd_d;
    logic [2:0]       rn_q, rn_d;
    logic [2:0]       rm_q, rm_d;
    logic [1:0]       shift_q, shift_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             err_q, err_d;

    // Next state and instruction latch; fields are captured only on accept.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        shift_d = shift_q;
        imm_d   = imm_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    rd_d    = bus.rd;
                    rn_d    = bus.rn;
                    rm_d    = bus.rm;
                    shift_d = bus.shift_in;
                    imm_d   = bus.imm;
                    err_d   = 1'b0;
                    case (bus.op)
                        OP_MOVI: state_d = S_WB_IMM;
                        OP_MOV,
                        OP_MVN:  state_d = S_LOAD_B;
                        OP_ADD,
                        OP_CMP,
                        OP_AND:  state_d = S_LOAD_A;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = (op_q == OP_CMP) ? S_DONE : S_WB_REG;
            S_WB_REG: state_d = S_DONE;
            S_WB_IMM: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and latched instruction; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
            imm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            shift_q <= shift_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    // Moore strobes decoded from state and the latched instruction only.
    always_comb begin
        bus.ready    = (state_q == S_IDLE);
        bus.readnum  = '0;
        bus.writenum = '0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.vsel     = 1'b0;
        bus.ALUop    = 2'b00;
        bus.shift    = 2'b00;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                bus.readnum = rn_q;
                bus.loada   = 1'b1;
            end
            S_LOAD_B: begin
                bus.readnum = rm_q;
                bus.loadb   = 1'b1;
            end
            S_EXEC: begin
                bus.shift = shift_q;
                unique case (1'b1)
                    (op_q == OP_ADD): bus.loadc = 1'b1;
                    (op_q == OP_CMP): begin
                        bus.ALUop = 2'b01;
                        bus.loads = 1'b1;
                    end
                    (op_q == OP_AND): begin
                        bus.ALUop = 2'b10;
                        bus.loadc = 1'b1;
                    end
                    (op_q == OP_MOV): begin
                        bus.asel  = 1'b1;
                        bus.loadc = 1'b1;
                    end
                    (op_q == OP_MVN): begin
                        bus.ALUop = 2'b11;
                        bus.loadc = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB_REG: begin
                bus.write    = 1'b1;
                bus.writenum = rd_q;
            end
            S_WB_IMM: begin
                bus.write    = 1'b1;
                bus.writenum = rd_q;
                bus.vsel     = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

    // Sign-extended immediate tracks the latch, so it holds between accepts.
    assign bus.sximm = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign bus.bsel  = 1'b0;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller for the 16-bit lab datapath: register file, A/B/C pipeline registers, shifter, ALU and status (Z) register.
- Accepts one decoded instruction per start/ready handshake.
- Steps the datapath through load-A, load-B, execute and write-back by driving Moore control strobes.
- Pulses done when the instruction retires.

Parameters:
- DATA_W, 16, datapath word width; also the width of sximm.
- IMM_W, 8, immediate field width; sign-extended to DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  instruction valid; accepted only when ready=1.
- ready  output  1  high only in IDLE.
- op  input  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 illegal.
- rd, rn, rm  input  3 each  destination and source register numbers.
- shift_in  input  2  shifter control for the Rm operand.
- imm  input  IMM_W  immediate value for MOVI.
- readnum  output  3  register-file read address.
- writenum  output  3  register-file write address.
- write  output  1  register-file write enable.
- loada, loadb, loadc, loads  output  1 each  load enables for A, B, C and status.
- asel  output  1  1 forces ALU Ain to 0.
- bsel  output  1  reserved; always 0.
- vsel  output  1  write-back source: 1 = sximm, 0 = C.
- ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT Bin.
- shift  output  2  shifter control.
- sximm  output  DATA_W  sign-extended latched immediate.
- done  output  1  one-cycle retire pulse.
- err  output  1  one-cycle pulse, coincident with done, for an illegal op.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE and the instruction latch clears.
  - ready=1; all other outputs 0, immediately and independent of clk.
  - Reset mid-instruction abandons it: no write, no done.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WB_REG, WB_IMM, DONE.
- All outputs are Moore outputs decoded from state plus the latched instruction.
  - Strobes are 0 outside the states listed below.
  - readnum, writenum, ALUop, shift, asel and vsel are 0 whenever not in use.
- IDLE:
  - On start=1, latch op/rd/rn/rm/shift_in/imm at the edge.
  - Next state: MOVI -> WB_IMM; MOV/MVN -> LOAD_B; ADD/CMP/AND -> LOAD_A; illegal -> DONE with err flag latched.
- LOAD_A: readnum=rn, loada=1. Next: LOAD_B.
- LOAD_B: readnum=rm, loadb=1. Next: EXEC.
- EXEC: shift=latched shift; ALUop and other signals per op:
  - ADD: ALUop=00, loadc=1.
  - CMP: ALUop=01, loads=1, loadc=0.
  - AND: ALUop=10, loadc=1.
  - MOV: ALUop=00, asel=1, loadc=1.
  - MVN: ALUop=11, loadc=1.
  - Next: CMP -> DONE; all others -> WB_REG.
- WB_REG: write=1, writenum=rd, vsel=0. Next: DONE.
- WB_IMM: write=1, writenum=rd, vsel=1. Next: DONE.
  - sximm = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}, held stable from the accept edge until the next accept.
- DONE: done=1; err=1 only for an illegal op. Next: IDLE.
- Latency, in cycles after the accept edge to the done cycle inclusive:
  - MOVI: 2.
  - Illegal: 1.
  - MOV, MVN, CMP: 4.
  - ADD, AND: 5.
- ready=0 from the accept edge through DONE. start while ready=0 is ignored, not queued.
- Back-to-back: start held high is accepted on the first IDLE cycle after DONE, so one instruction starts every N+1 cycles.
- Input fields may change freely after the accept edge; only latched values drive outputs.
- At most one of write, loada, loadb, loadc, loads is high in any cycle.

Test Plan:
- Reset: assert reset_n=0 mid-EXEC of an ADD -> within the same timestep all strobes=0 and ready=1; no write or done follows release.
- MOVI rd=3, imm=8'hF6 -> next cycle write=1, writenum=3, vsel=1, sximm=16'hFFF6; following cycle done=1; then ready=1.
- ADD rd=2, rn=0, rm=1, shift_in=01 -> cycle 1 loada=1/readnum=0; cycle 2 loadb=1/readnum=1; cycle 3 loadc=1/ALUop=00/shift=01; cycle 4 write=1/writenum=2/vsel=0; cycle 5 done=1.
- CMP rn=4, rm=4 -> EXEC has loads=1, loadc=0, ALUop=01; done in cycle 4; write never asserted.
- MVN rd=7, rm=5 -> no loada cycle; cycle 1 loadb=1/readnum=5; cycle 2 ALUop=11/loadc=1; cycle 3 write=1/writenum=7; cycle 4 done=1.
- op=3'b110 with start held high throughout -> next cycle done=1 and err=1 with all strobes 0; the second accept happens on the following IDLE cycle; a start pulse during busy cycles is ignored.
